// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 controller, one 16-bit frame per request, MSB first
// Optional CIPO readback of the data byte on read frames: SPI_CONTROLLER_CIPO_EN
module spi_controller #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4,
   parameter int CS_IDLE  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
`ifdef SPI_CONTROLLER_CIPO_EN
   input  logic       CIPO,
   output logic [7:0] rdata,
`endif
   output logic       busy,
   output logic       done,
   output logic       SCLK,
   output logic       COPI,
   output logic       nCS
);

   localparam int CMAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int CMAX_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
   localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
   localparam int CW     = $clog2(CMAX + 1);

   localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
   localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   // Bit 15 goes straight to COPI on acceptance, so only bits 14:0 are kept
   logic [14:0]   shift_q, shift_d;
   logic [4:0]    rise_q, rise_d;
   logic          sclk_q, sclk_d;
   logic          copi_q, copi_d;
   logic          ncs_q, ncs_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
`ifdef SPI_CONTROLLER_CIPO_EN
   logic          rw_q, rw_d;
   logic [7:0]    shadow_q, shadow_d;
   logic [7:0]    rdata_q, rdata_d;
`endif

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      rise_d   = rise_q;
      sclk_d   = sclk_q;
      copi_d   = copi_q;
      ncs_d    = ncs_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef SPI_CONTROLLER_CIPO_EN
      rw_d     = rw_q;
      shadow_d = shadow_q;
      rdata_d  = rdata_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d = {addr, wdata};
               copi_d  = rw;
               ncs_d   = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               rise_d  = 5'd0;
               state_d = S_SETUP;
`ifdef SPI_CONTROLLER_CIPO_EN
               rw_d    = rw;
`endif
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               sclk_d  = 1'b1;
               rise_d  = 5'd1;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_SHIFT: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d = '0;
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  if (rise_q == 5'd16) begin
                     state_d = S_HOLD;
                  end else begin
                     copi_d  = shift_q[14];
                     shift_d = {shift_q[13:0], 1'b0};
                  end
               end else begin
                  sclk_d = 1'b1;
                  rise_d = rise_q + 5'd1;
`ifdef SPI_CONTROLLER_CIPO_EN
                  // rise_q still holds the previous count: 8..15 means edges 9..16
                  if (rise_q >= 5'd8) begin
                     shadow_d = {shadow_q[6:0], CIPO};
                  end
`endif
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               ncs_d   = 1'b1;
               copi_d  = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_GAP;
`ifdef SPI_CONTROLLER_CIPO_EN
               if (!rw_q) begin
                  rdata_d = shadow_q;
               end
`endif
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_GAP: begin
            if (cnt_q == IDLE_LAST) begin
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sclk_d  = 1'b0;
            copi_d  = 1'b0;
            ncs_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         rise_q   <= 5'd0;
         sclk_q   <= 1'b0;
         copi_q   <= 1'b0;
         ncs_q    <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SPI_CONTROLLER_CIPO_EN
         rw_q     <= 1'b0;
         shadow_q <= 8'h00;
         rdata_q  <= 8'h00;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         rise_q   <= rise_d;
         sclk_q   <= sclk_d;
         copi_q   <= copi_d;
         ncs_q    <= ncs_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SPI_CONTROLLER_CIPO_EN
         rw_q     <= rw_d;
         shadow_q <= shadow_d;
         rdata_q  <= rdata_d;
`endif
      end
   end

   assign SCLK = sclk_q;
   assign COPI = copi_q;
   assign nCS  = ncs_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef SPI_CONTROLLER_CIPO_EN
   assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - randomized bench for spi_controller, default and swept instances
// Drives CIPO and checks rdata when SPI_CONTROLLER_CIPO_EN is defined
module tb_spi_controller;

   typedef struct {
      logic [15:0] word;
      int          rises;
      int          low_len;
      int          setup;
      int          hold;
      int          viol;
      int          gap;
      logic        done_at_rise;
      logic [7:0]  rd;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] start_v = 2'b00;
   logic [1:0] rw_v = 2'b00;
   logic [6:0] addr_v [2];
   logic [7:0] wdata_v [2];
   logic [1:0] busy_v, done_v, sclk_v, copi_v, ncs_v;
`ifdef SPI_CONTROLLER_CIPO_EN
   logic       cipo0 = 1'b0;
   logic [7:0] cipo_byte = 8'h00;
   logic [7:0] rdata_v [2];
`endif

   // Timing parameters of instance 0 (defaults) and instance 1 (sweep)
   int cd [2] = '{4, 7};
   int su [2] = '{4, 1};
   int ho [2] = '{4, 1};
   int gi [2] = '{8, 1};

   int n_checks = 0;
   int n_fail   = 0;

   frame_t q [$];
   int   cyc = 0;
   logic [1:0] p_sclk = 2'b00, p_copi = 2'b00, p_ncs = 2'b11, p_busy = 2'b00;
   bit   in_frame [2];
   int   t_fall [2], t_lastrise [2], t_lastfall [2], t_copi [2], first_rise [2];
   int   t_ncs_up [2] = '{-1, -1};
   int   rises [2], falls [2], viol [2], dones [2];
   int   last_d2b [2], last_dones [2];
   int   gap_cur [2];
   logic [15:0] word_a [2];

   always #5 clk = ~clk;

   spi_controller dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .rw(rw_v[0]),
      .addr(addr_v[0]), .wdata(wdata_v[0]),
`ifdef SPI_CONTROLLER_CIPO_EN
      .CIPO(cipo0), .rdata(rdata_v[0]),
`endif
      .busy(busy_v[0]), .done(done_v[0]), .SCLK(sclk_v[0]),
      .COPI(copi_v[0]), .nCS(ncs_v[0])
   );

   spi_controller #(.CLK_DIV(7), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .rw(rw_v[1]),
      .addr(addr_v[1]), .wdata(wdata_v[1]),
`ifdef SPI_CONTROLLER_CIPO_EN
      .CIPO(1'b0), .rdata(rdata_v[1]),
`endif
      .busy(busy_v[1]), .done(done_v[1]), .SCLK(sclk_v[1]),
      .COPI(copi_v[1]), .nCS(ncs_v[1])
   );

   // Peripheral-side monitor: rebuilds each frame from the pins alone
   always @(negedge clk) begin
      frame_t r;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         bit m;
         m = i[0];
         if (rst) begin
            in_frame[m] = 1'b0;
            rises[m] = 0;
            falls[m] = 0;
         end else begin
            if (p_ncs[m] && !ncs_v[m]) begin
               in_frame[m] = 1'b1;
               t_fall[m] = cyc;
               t_copi[m] = cyc;
               rises[m] = 0;
               falls[m] = 0;
               viol[m] = 0;
               dones[m] = 0;
               word_a[m] = 16'h0000;
               gap_cur[m] = (t_ncs_up[m] >= 0) ? cyc - t_ncs_up[m] : -1;
`ifdef SPI_CONTROLLER_CIPO_EN
               if (m == 1'b0) cipo0 = 1'b0;
`endif
            end
            if (done_v[m]) dones[m]++;
            if (in_frame[m] && !p_sclk[m] && sclk_v[m]) begin
               rises[m]++;
               word_a[m] = {word_a[m][14:0], copi_v[m]};
               if (rises[m] == 1) first_rise[m] = cyc;
               else if (cyc - t_copi[m] < cd[m]) viol[m]++;
               t_lastrise[m] = cyc;
            end
            if (in_frame[m] && p_sclk[m] && !sclk_v[m]) begin
               falls[m]++;
               t_lastfall[m] = cyc;
`ifdef SPI_CONTROLLER_CIPO_EN
               if (m == 1'b0 && falls[m] >= 8 && falls[m] <= 15)
                  cipo0 = cipo_byte[3'(15 - falls[m])];
`endif
            end
            if (in_frame[m] && !ncs_v[m] && copi_v[m] != p_copi[m]) begin
               if (rises[m] > 0 && cyc - t_lastrise[m] < cd[m]) viol[m]++;
               t_copi[m] = cyc;
            end
            if (in_frame[m] && !p_ncs[m] && ncs_v[m]) begin
               r.word = word_a[m];
               r.rises = rises[m];
               r.low_len = cyc - t_fall[m];
               r.setup = first_rise[m] - t_fall[m];
               r.hold = cyc - t_lastfall[m];
               r.viol = viol[m];
               r.gap = gap_cur[m];
               r.done_at_rise = done_v[m];
`ifdef SPI_CONTROLLER_CIPO_EN
               r.rd = rdata_v[m];
`else
               r.rd = 8'h00;
`endif
               q.push_back(r);
               in_frame[m] = 1'b0;
               t_ncs_up[m] = cyc;
            end
            if (p_busy[m] && !busy_v[m]) begin
               last_d2b[m] = cyc - t_ncs_up[m];
               last_dones[m] = dones[m];
            end
         end
         p_sclk[m] = sclk_v[m];
         p_copi[m] = copi_v[m];
         p_ncs[m]  = ncs_v[m];
         p_busy[m] = busy_v[m];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_busy(input bit m, input logic lvl, input string tag);
      int n = 0;
      while (busy_v[m] !== lvl && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({"busy_wait_", tag}, 32'(busy_v[m] === lvl), 32'd1);
   endtask

   task automatic scramble(input bit m);
      logic [31:0] r;
      r = $urandom;
      rw_v[m] = r[0];
      addr_v[m] = r[7:1];
      wdata_v[m] = r[15:8];
   endtask

   task automatic take(output frame_t rec, output bit ok);
      ok = (q.size() != 0);
      check("frame_seen", 32'(ok), 32'd1);
      if (ok) rec = q.pop_front();
   endtask

   task automatic verify(input bit m, input frame_t rec, input logic [15:0] exp, input bit with_end);
      check("word", 32'(rec.word), 32'(exp));
      check("rises", rec.rises, 16);
      check("ncs_low", rec.low_len, su[m] + 31 * cd[m] + ho[m]);
      check("setup", rec.setup, su[m]);
      check("hold", rec.hold, ho[m]);
      check("copi_stable", rec.viol, 0);
      check("done_at_ncs_rise", 32'(rec.done_at_rise), 32'd1);
      if (with_end) begin
         check("busy_after_done", last_d2b[m], gi[m]);
         check("done_pulses", last_dones[m], 1);
      end
   endtask

   task automatic run_frame(input bit m, input logic frw, input logic [6:0] fa,
                            input logic [7:0] fd, output frame_t rec);
      bit ok;
      @(negedge clk);
      rw_v[m] = frw;
      addr_v[m] = fa;
      wdata_v[m] = fd;
      start_v[m] = 1'b1;
      wait_busy(m, 1'b1, "accept");
      start_v[m] = 1'b0;
      scramble(m);
      wait_busy(m, 1'b0, "end");
      @(negedge clk);
      take(rec, ok);
      if (ok) verify(m, rec, {frw, fa, fd}, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      frame_t rec, rec2;
      bit ok, ok2;
      logic [31:0] r;
      int n;
      addr_v[0] = 7'h00; addr_v[1] = 7'h00;
      wdata_v[0] = 8'h00; wdata_v[1] = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_pins0", 32'({sclk_v[0], copi_v[0], ncs_v[0], busy_v[0], done_v[0]}), 32'h04);
      check("reset_pins1", 32'({sclk_v[1], copi_v[1], ncs_v[1], busy_v[1], done_v[1]}), 32'h04);
`ifdef SPI_CONTROLLER_CIPO_EN
      check("reset_rdata", 32'(rdata_v[0]), 32'h00);
`endif
      rst = 1'b0;

      run_frame(1'b0, 1'b1, 7'h00, 8'hA5, rec);
      repeat (6) begin
         r = $urandom;
         run_frame(1'b0, r[0], r[7:1], r[15:8], rec);
      end

      // Start held across two frames; inputs change while the first is on the wire
      @(negedge clk);
      rw_v[0] = 1'b1; addr_v[0] = 7'h01; wdata_v[0] = 8'h55; start_v[0] = 1'b1;
      wait_busy(1'b0, 1'b1, "b2b_acc1");
      addr_v[0] = 7'h04; wdata_v[0] = 8'hFF;
      wait_busy(1'b0, 1'b0, "b2b_end1");
      wait_busy(1'b0, 1'b1, "b2b_acc2");
      start_v[0] = 1'b0;
      scramble(1'b0);
      wait_busy(1'b0, 1'b0, "b2b_end2");
      @(negedge clk);
      take(rec, ok);
      take(rec2, ok2);
      if (ok) verify(1'b0, rec, 16'h8155, 1'b0);
      if (ok2) begin
         verify(1'b0, rec2, 16'h84FF, 1'b1);
         check("b2b_gap_min", 32'(rec2.gap >= gi[0]), 32'd1);
      end

      // Asynchronous reset after rising edge 6
      @(negedge clk);
      r = $urandom;
      rw_v[0] = r[0]; addr_v[0] = r[7:1]; wdata_v[0] = r[15:8]; start_v[0] = 1'b1;
      wait_busy(1'b0, 1'b1, "rst_acc");
      start_v[0] = 1'b0;
      @(negedge clk);
      n = 0;
      while (rises[0] < 6 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reach_rise6", 32'(rises[0] >= 6), 32'd1);
      #2 rst = 1'b1;
      #1 check("rst_async", 32'({sclk_v[0], ncs_v[0], busy_v[0]}), 32'b010);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("no_partial_frame", q.size(), 0);
      run_frame(1'b0, 1'b1, 7'h02, 8'h03, rec);

      run_frame(1'b1, 1'b1, 7'h03, 8'h80, rec);
      repeat (2) begin
         r = $urandom;
         run_frame(1'b1, r[0], r[7:1], r[15:8], rec);
      end

`ifdef SPI_CONTROLLER_CIPO_EN
      cipo_byte = 8'h3C;
      run_frame(1'b0, 1'b0, 7'h04, 8'h00, rec);
      check("rdata_at_done", 32'(rec.rd), 32'h3C);
      cipo_byte = 8'hC3;
      run_frame(1'b0, 1'b1, 7'h05, 8'h11, rec);
      check("rdata_kept_write_done", 32'(rec.rd), 32'h3C);
      check("rdata_kept_after", 32'(rdata_v[0]), 32'h3C);
      repeat (3) begin
         r = $urandom;
         cipo_byte = r[23:16];
         run_frame(1'b0, 1'b0, r[7:1], r[15:8], rec);
         check("rdata_rand", 32'(rec.rd), 32'(r[23:16]));
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
